// File: rtl/sync_fifo_param.sv
// Synchronous single-clock FIFO with parametrised width/depth, programmable
// almost-full/almost-empty thresholds, selectable registered or
// first-word-fall-through read data, synchronous flush and high-water mark.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int AF_THRESH  = FIFO_DEPTH - 1,
    parameter int AE_THRESH  = 1,
    parameter int FWFT       = 0
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                clr,
    input  logic                                wr_en,
    input  logic [DATA_WIDTH-1:0]               data_in,
    input  logic                                rd_en,
    output logic [DATA_WIDTH-1:0]               data_out,
    output logic                                wr_ack,
    output logic                                overflow,
    output logic                                underflow,
    output logic                                full,
    output logic                                empty,
    output logic                                almostfull,
    output logic                                almostempty,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     count,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]     hwm
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    // Reject illegal parameter combinations at elaboration.
    if (DATA_WIDTH < 1 || FIFO_DEPTH < 2 || AE_THRESH < 1 ||
        AE_THRESH >= AF_THRESH || AF_THRESH > FIFO_DEPTH - 1) begin : g_param_err
        $error("sync_fifo_param: illegal DATA_WIDTH/FIFO_DEPTH/AF_THRESH/AE_THRESH");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] hwm_q, hwm_d;
    logic          wr_ack_q, wr_ack_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          wr_do, rd_do;

    // Depth need not be a power of two, so wrap on an explicit compare.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full        = (count_q == CW'(FIFO_DEPTH));
    assign empty       = (count_q == '0);
    assign almostfull  = (count_q >= CW'(AF_THRESH)) && !full;
    assign almostempty = (count_q <= CW'(AE_THRESH)) && !empty;
    assign count       = count_q;
    assign hwm         = hwm_q;
    assign wr_ack      = wr_ack_q;
    assign overflow    = overflow_q;
    assign underflow   = underflow_q;

    // Next-state: clr overrides any request; otherwise accept per full/empty.
    always_comb begin
        wr_do    = wr_en && !full && !clr;
        rd_do    = rd_en && !empty && !clr;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_do) wr_ptr_d = next_ptr(wr_ptr_q);
            if (rd_do) rd_ptr_d = next_ptr(rd_ptr_q);
            if (wr_do && !rd_do)      count_d = count_q + CW'(1);
            else if (!wr_do && rd_do) count_d = count_q - CW'(1);
        end
        hwm_d       = clr ? '0 : ((count_d > hwm_q) ? count_d : hwm_q);
        wr_ack_d    = wr_do;
        overflow_d  = wr_en && full && !clr;
        // A read against an empty FIFO alongside a write is a write-only
        // cycle, not a rejected read.
        underflow_d = rd_en && empty && !wr_en && !clr;
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hwm_q       <= '0;
            wr_ack_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            hwm_q       <= hwm_d;
            wr_ack_q    <= wr_ack_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_do) mem_q[wr_ptr_q] <= data_in;
    end

    if (FWFT != 0) begin : g_fwft
        assign data_out = mem_q[rd_ptr_q];
    end else begin : g_reg
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        assign dout_d   = rd_do ? mem_q[rd_ptr_q] : dout_q;
        assign data_out = dout_q;

        // Registered read data: load on an accepted read, otherwise hold.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) dout_q <= '0;
            else        dout_q <= dout_d;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: one registered-read and one FWFT
// instance share stimulus and are checked every cycle against a queue model.
module tb_sync_fifo_param;

    localparam int DW = 16;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic [DW-1:0] data_in = '0;

    logic [DW-1:0] dout   [2];
    logic [CW-1:0] cnt    [2];
    logic [CW-1:0] hwmv   [2];
    logic [1:0]    wr_ack, ovf, unf, full, empty, af, ae;

    // Model state
    logic [DW-1:0] mq [$];
    int            m_hwm;
    logic          m_ack, m_ov, m_un;
    logic [DW-1:0] m_dout0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT(0)) u_reg (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout[0]), .wr_ack(wr_ack[0]), .overflow(ovf[0]),
        .underflow(unf[0]), .full(full[0]), .empty(empty[0]), .almostfull(af[0]),
        .almostempty(ae[0]), .count(cnt[0]), .hwm(hwmv[0])
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(D), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .data_in(data_in),
        .rd_en(rd_en), .data_out(dout[1]), .wr_ack(wr_ack[1]), .overflow(ovf[1]),
        .underflow(unf[1]), .full(full[1]), .empty(empty[1]), .almostfull(af[1]),
        .almostempty(ae[1]), .count(cnt[1]), .hwm(hwmv[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_hwm   = 0;
        m_ack   = 1'b0;
        m_ov    = 1'b0;
        m_un    = 1'b0;
        m_dout0 = '0;
    endtask

    task automatic model_step(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        bit is_full, is_empty, wacc, racc;
        is_full  = (mq.size() == D);
        is_empty = (mq.size() == 0);
        if (c) begin
            mq.delete();
            m_hwm = 0;
            m_ack = 1'b0;
            m_ov  = 1'b0;
            m_un  = 1'b0;
        end else begin
            wacc  = w && !is_full;
            racc  = r && !is_empty;
            m_ack = wacc;
            m_ov  = w && is_full;
            m_un  = r && is_empty && !w;
            if (racc) m_dout0 = mq.pop_front();
            if (wacc) mq.push_back(d);
            if (mq.size() > m_hwm) m_hwm = mq.size();
        end
    endtask

    // One clock cycle of stimulus; returns at the following falling edge.
    task automatic cyc(input logic w, input logic r, input logic c, input logic [DW-1:0] d);
        wr_en   = w;
        rd_en   = r;
        clr     = c;
        data_in = d;
        @(posedge clk);
        if (rst_n) model_step(w, r, c, d);
        @(negedge clk);
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin : cmp
        int n;
        n = mq.size();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("count%0d", i),     32'(cnt[i]),    32'(n));
            chk($sformatf("hwm%0d", i),       32'(hwmv[i]),   32'(m_hwm));
            chk($sformatf("full%0d", i),      32'(full[i]),   32'(n == D));
            chk($sformatf("empty%0d", i),     32'(empty[i]),  32'(n == 0));
            chk($sformatf("afull%0d", i),     32'(af[i]),     32'(n >= D - 1 && n != D));
            chk($sformatf("aempty%0d", i),    32'(ae[i]),     32'(n <= 1 && n != 0));
            chk($sformatf("wr_ack%0d", i),    32'(wr_ack[i]), 32'(m_ack));
            chk($sformatf("overflow%0d", i),  32'(ovf[i]),    32'(m_ov));
            chk($sformatf("underflow%0d", i), 32'(unf[i]),    32'(m_un));
        end
        chk("dout_reg", 32'(dout[0]), 32'(m_dout0));
        if (n > 0) chk("dout_fwft", 32'(dout[1]), 32'(mq[0]));
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_count", 32'(cnt[0]), 0);
        chk("rst_empty", 32'(empty[0]), 1);
        chk("rst_dout", 32'(dout[0]), 0);
        rst_n = 1'b1;

        // Fill with 1..8
        for (int i = 1; i <= 8; i++) begin
            cyc(1'b1, 1'b0, 1'b0, DW'(i));
            chk("t1_ack", 32'(wr_ack[0]), 1);
            if (i == 1) chk("t1_aempty", 32'(ae[0]), 1);
            if (i == 7) chk("t1_afull", 32'(af[0]), 1);
        end
        chk("t1_full", 32'(full[0]), 1);
        chk("t1_hwm", 32'(hwmv[0]), 8);

        // Write while full, then write+read while full
        cyc(1'b1, 1'b0, 1'b0, 16'h0009);
        chk("t2_overflow", 32'(ovf[0]), 1);
        chk("t2_ack", 32'(wr_ack[0]), 0);
        chk("t2_count", 32'(cnt[0]), 8);
        cyc(1'b1, 1'b1, 1'b0, 16'h0009);
        chk("t2_rd_count", 32'(cnt[0]), 7);
        chk("t2_rd_ack", 32'(wr_ack[0]), 0);
        chk("t2_rd_data", 32'(dout[0]), 32'h0001);

        // Drain the rest, then read while empty
        for (int i = 2; i <= 8; i++) begin
            cyc(1'b0, 1'b1, 1'b0, '0);
            chk("t3_data", 32'(dout[0]), 32'(i));
        end
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("t3_underflow", 32'(unf[0]), 1);
        chk("t3_hold", 32'(dout[0]), 32'h0008);

        // Simultaneous write+read when empty and when partly full
        cyc(1'b1, 1'b1, 1'b0, 16'h0011);
        chk("t4_count", 32'(cnt[0]), 1);
        chk("t4_ack", 32'(wr_ack[0]), 1);
        chk("t4_underflow", 32'(unf[0]), 0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, DW'(16'h0012 + i));
        cyc(1'b1, 1'b1, 1'b0, 16'h0015);
        chk("t4_mid_count", 32'(cnt[0]), 4);
        chk("t4_mid_ack", 32'(wr_ack[0]), 1);
        chk("t4_mid_data", 32'(dout[0]), 32'h0011);
        repeat (4) cyc(1'b0, 1'b1, 1'b0, '0);
        chk("t4_last", 32'(dout[0]), 32'h0015);

        // FWFT fall-through
        cyc(1'b1, 1'b0, 1'b0, 16'h00AA);
        chk("t5_fwft_data", 32'(dout[1]), 32'h00AA);
        chk("t5_not_empty", 32'(empty[1]), 0);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("t5_empty", 32'(empty[1]), 1);

        // Flush with a concurrent write
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b0, DW'(16'h0021 + i));
        chk("t6_count5", 32'(cnt[0]), 5);
        cyc(1'b1, 1'b0, 1'b1, 16'h0026);
        chk("t6_clr_count", 32'(cnt[0]), 0);
        chk("t6_clr_hwm", 32'(hwmv[0]), 0);
        chk("t6_clr_empty", 32'(empty[0]), 1);
        chk("t6_clr_ack", 32'(wr_ack[0]), 0);
        chk("t6_clr_dout", 32'(dout[0]), 32'h00AA);

        // Asynchronous reset in the middle of a write burst
        cyc(1'b1, 1'b0, 1'b0, 16'h0031);
        cyc(1'b1, 1'b0, 1'b0, 16'h0032);
        wr_en   = 1'b1;
        data_in = 16'h0033;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_rst_count", 32'(cnt[0]), 0);
        chk("t6_rst_hwm", 32'(hwmv[0]), 0);
        chk("t6_rst_ack", 32'(wr_ack[0]), 0);
        chk("t6_rst_ovf", 32'(ovf[0]), 0);
        chk("t6_rst_unf", 32'(unf[0]), 0);
        chk("t6_rst_dout", 32'(dout[0]), 0);
        chk("t6_rst_count_fwft", 32'(cnt[1]), 0);
        @(negedge clk);
        wr_en = 1'b0;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 16'h0041);
        chk("t6_post_count", 32'(cnt[0]), 1);
        chk("t6_post_hwm", 32'(hwmv[0]), 1);
        cyc(1'b0, 1'b1, 1'b0, '0);
        chk("t6_post_data", 32'(dout[0]), 32'h0041);
        cyc(1'b0, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
